// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the Pong game sequencer and the ball/collision datapath.
// The sequencer side (master) drives the ball-control, serve and display values.
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       start_btn;
    logic       paddle_hit;
    logic [8:0] ballY;
    logic       ball_run;
    logic       ball_load;
    logic [9:0] serve_x;
    logic [8:0] serve_y;
    logic       serve_dirX;
    logic [2:0] ball_speed;
    logic [7:0] score;
    logic [1:0] lives;
    logic [1:0] state;

    modport master (
        input  frame_tick, start_btn, paddle_hit, ballY,
        output ball_run, ball_load, serve_x, serve_y, serve_dirX,
               ball_speed, score, lives, state
    );

    modport slave (
        output frame_tick, start_btn, paddle_hit, ballY,
        input  ball_run, ball_load, serve_x, serve_y, serve_dirX,
               ball_speed, score, lives, state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: freezes, serves and releases the ball, and keeps the
// BCD score, lives and ball speed. All outputs are registered.
module pong_game_ctrl #(
    parameter logic [9:0] SERVE_X      = 10'd320,
    parameter logic [8:0] SERVE_Y      = 9'd64,
    parameter logic [7:0] SERVE_DELAY  = 8'd60,
    parameter logic [1:0] LIVES        = 2'd3,
    parameter logic [8:0] MISS_Y       = 9'd472,
    parameter logic [3:0] SPEEDUP_HITS = 4'd4,
    parameter logic [2:0] MAX_SPEED    = 3'd4
) (
    input logic             clk,
    input logic             rst,
    pong_game_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t     curState, nxtState;
    logic       startD, startArmed;
    logic       runReg, runNxt;
    logic       loadReg, loadNxt;
    logic       dirXReg, dirXNxt;
    logic [2:0] speedReg, speedNxt;
    logic [7:0] scoreReg, scoreNxt;
    logic [1:0] livesReg, livesNxt;
    logic [3:0] hitCnt, hitNxt;
    logic [3:0] hitInc;
    logic [7:0] delayCnt, delayNxt;
    logic       startEdge;
    logic       miss;

    function automatic logic [7:0] bcdInc(input logic [7:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        ones = v[3:0];
        tens = v[7:4];
        if (ones == 4'd9) begin
            ones = 4'd0;
            if (tens == 4'd9) begin
                tens = 4'd0;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    // A button held through reset must be seen low once before an edge counts.
    assign startEdge = bus.start_btn & ~startD & startArmed;
    assign miss      = bus.frame_tick & (bus.ballY >= MISS_Y);
    assign hitInc    = hitCnt + 4'd1;

    // Next-state and next-output decode for the game sequencer.
    always_comb begin
        nxtState = curState;
        loadNxt  = 1'b0;
        dirXNxt  = dirXReg;
        speedNxt = speedReg;
        scoreNxt = scoreReg;
        livesNxt = livesReg;
        hitNxt   = hitCnt;
        delayNxt = delayCnt;

        case (curState)
            IDLE, OVER: begin
                if (startEdge) begin
                    livesNxt = LIVES;
                    scoreNxt = 8'h00;
                    speedNxt = 3'd1;
                    hitNxt   = 4'd0;
                    delayNxt = SERVE_DELAY;
                    loadNxt  = 1'b1;
                    nxtState = SERVE;
                end else begin
                    nxtState = curState;
                end
            end
            SERVE: begin
                if (bus.frame_tick) begin
                    delayNxt = delayCnt - 8'd1;
                    if (delayCnt == 8'd1) begin
                        nxtState = PLAY;
                    end else begin
                        nxtState = SERVE;
                    end
                end else begin
                    delayNxt = delayCnt;
                end
            end
            PLAY: begin
                if (bus.paddle_hit) begin
                    scoreNxt = bcdInc(scoreReg);
                    if (hitInc == SPEEDUP_HITS) begin
                        hitNxt   = 4'd0;
                        speedNxt = (speedReg < MAX_SPEED) ? speedReg + 3'd1 : MAX_SPEED;
                    end else begin
                        hitNxt = hitInc;
                    end
                end else begin
                    scoreNxt = scoreReg;
                end
                // The miss is applied after the hit so its speed reset wins.
                if (miss) begin
                    if (livesReg == 2'd1) begin
                        livesNxt = 2'd0;
                        nxtState = OVER;
                    end else begin
                        livesNxt = livesReg - 2'd1;
                        speedNxt = 3'd1;
                        hitNxt   = 4'd0;
                        dirXNxt  = ~dirXReg;
                        delayNxt = SERVE_DELAY;
                        loadNxt  = 1'b1;
                        nxtState = SERVE;
                    end
                end else begin
                    livesNxt = livesReg;
                end
            end
            default: begin
                nxtState = IDLE;
            end
        endcase

        runNxt = (nxtState == PLAY);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            curState   <= IDLE;
            startD     <= 1'b0;
            startArmed <= 1'b0;
            runReg     <= 1'b0;
            loadReg    <= 1'b0;
            dirXReg    <= 1'b0;
            speedReg   <= 3'd1;
            scoreReg   <= 8'h00;
            livesReg   <= 2'd0;
            hitCnt     <= 4'd0;
            delayCnt   <= 8'd0;
        end else begin
            curState   <= nxtState;
            startD     <= bus.start_btn;
            startArmed <= startArmed | ~bus.start_btn;
            runReg     <= runNxt;
            loadReg    <= loadNxt;
            dirXReg    <= dirXNxt;
            speedReg   <= speedNxt;
            scoreReg   <= scoreNxt;
            livesReg   <= livesNxt;
            hitCnt     <= hitNxt;
            delayCnt   <= delayNxt;
        end
    end

    assign bus.ball_run   = runReg;
    assign bus.ball_load  = loadReg;
    assign bus.serve_x    = SERVE_X;
    assign bus.serve_y    = SERVE_Y;
    assign bus.serve_dirX = dirXReg;
    assign bus.ball_speed = speedReg;
    assign bus.score      = scoreReg;
    assign bus.lives      = livesReg;
    assign bus.state      = curState;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl with default parameters.
module tb_pong_game_ctrl;

    logic clk;
    logic rst;
    int   assertCnt;
    int   failCnt;

    pong_game_ctrl_if bus ();

    pong_game_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic hits(input int n);
        bus.paddle_hit = 1'b1;
        repeat (n) cyc();
        bus.paddle_hit = 1'b0;
    endtask

    task automatic frame(input logic [8:0] y);
        bus.ballY      = y;
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        bus.ballY      = 9'd100;
    endtask

    task automatic serveFrames(input int n);
        for (int i = 0; i < n; i++) begin
            frame(9'd100);
            cyc();
        end
    endtask

    task automatic pressStart();
        bus.start_btn = 1'b1;
        cyc();
        bus.start_btn = 1'b0;
    endtask

    initial begin
        assertCnt      = 0;
        failCnt        = 0;
        rst            = 1'b1;
        bus.frame_tick = 1'b0;
        bus.start_btn  = 1'b0;
        bus.paddle_hit = 1'b0;
        bus.ballY      = 9'd100;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        cyc();

        checkVal("rst_state", bus.state, 32'd0);
        checkVal("rst_run", bus.ball_run, 32'd0);
        checkVal("rst_load", bus.ball_load, 32'd0);
        checkVal("rst_score", bus.score, 32'h00);
        checkVal("rst_lives", bus.lives, 32'd0);
        checkVal("rst_speed", bus.ball_speed, 32'd1);
        checkVal("rst_dirx", bus.serve_dirX, 32'd0);
        checkVal("serve_x", bus.serve_x, 32'd320);
        checkVal("serve_y", bus.serve_y, 32'd64);

        pressStart();
        checkVal("start_load", bus.ball_load, 32'd1);
        checkVal("start_state", bus.state, 32'd1);
        checkVal("start_lives", bus.lives, 32'd3);
        checkVal("start_score", bus.score, 32'h00);
        checkVal("start_run", bus.ball_run, 32'd0);
        cyc();
        checkVal("load_drop", bus.ball_load, 32'd0);

        hits(1);
        checkVal("serve_hit_ign", bus.score, 32'h00);

        serveFrames(59);
        checkVal("frz59_state", bus.state, 32'd1);
        checkVal("frz59_run", bus.ball_run, 32'd0);
        frame(9'd100);
        checkVal("play_state", bus.state, 32'd2);
        checkVal("play_run", bus.ball_run, 32'd1);

        hits(4);
        checkVal("hit4_score", bus.score, 32'h04);
        checkVal("hit4_speed", bus.ball_speed, 32'd2);
        hits(8);
        checkVal("hit12_score", bus.score, 32'h12);
        checkVal("hit12_speed", bus.ball_speed, 32'd4);
        hits(4);
        checkVal("hit16_score", bus.score, 32'h16);
        checkVal("speed_cap", bus.ball_speed, 32'd4);

        pressStart();
        cyc();
        checkVal("play_start_state", bus.state, 32'd2);
        checkVal("play_start_score", bus.score, 32'h16);
        checkVal("play_start_load", bus.ball_load, 32'd0);

        frame(9'd471);
        checkVal("nomiss_lives", bus.lives, 32'd3);
        checkVal("nomiss_state", bus.state, 32'd2);
        frame(9'd472);
        checkVal("miss_lives", bus.lives, 32'd2);
        checkVal("miss_load", bus.ball_load, 32'd1);
        checkVal("miss_dirx", bus.serve_dirX, 32'd1);
        checkVal("miss_speed", bus.ball_speed, 32'd1);
        checkVal("miss_state", bus.state, 32'd1);
        checkVal("miss_run", bus.ball_run, 32'd0);

        serveFrames(60);
        checkVal("replay_state", bus.state, 32'd2);
        hits(83);
        checkVal("score99", bus.score, 32'h99);
        hits(1);
        checkVal("score_wrap", bus.score, 32'h00);
        checkVal("wrap_speed", bus.ball_speed, 32'd4);

        bus.paddle_hit = 1'b1;
        frame(9'd480);
        bus.paddle_hit = 1'b0;
        checkVal("sim_score", bus.score, 32'h01);
        checkVal("sim_lives", bus.lives, 32'd1);
        checkVal("sim_speed", bus.ball_speed, 32'd1);
        checkVal("sim_state", bus.state, 32'd1);
        checkVal("sim_dirx", bus.serve_dirX, 32'd0);

        serveFrames(60);
        frame(9'd500);
        checkVal("over_lives", bus.lives, 32'd0);
        checkVal("over_state", bus.state, 32'd3);
        checkVal("over_run", bus.ball_run, 32'd0);
        checkVal("over_load", bus.ball_load, 32'd0);
        hits(1);
        checkVal("over_score", bus.score, 32'h01);

        pressStart();
        checkVal("new_state", bus.state, 32'd1);
        checkVal("new_score", bus.score, 32'h00);
        checkVal("new_lives", bus.lives, 32'd3);
        checkVal("new_load", bus.ball_load, 32'd1);

        serveFrames(60);
        hits(5);
        checkVal("pre_rst_score", bus.score, 32'h05);
        bus.start_btn = 1'b1;
        rst           = 1'b1;
        cyc();
        rst = 1'b0;
        checkVal("mid_rst_state", bus.state, 32'd0);
        checkVal("mid_rst_run", bus.ball_run, 32'd0);
        checkVal("mid_rst_score", bus.score, 32'h00);
        checkVal("mid_rst_lives", bus.lives, 32'd0);
        checkVal("mid_rst_speed", bus.ball_speed, 32'd1);
        repeat (3) cyc();
        checkVal("held_btn_idle", bus.state, 32'd0);
        checkVal("held_btn_load", bus.ball_load, 32'd0);
        bus.start_btn = 1'b0;
        cyc();
        pressStart();
        checkVal("rearm_state", bus.state, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
